// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two
// requesters. A granted request's operands are held on the ALU inputs for
// SETTLE_CYCLES cycles. The result and flags are then captured into a
// response register and returned over a valid/ready handshake.
//
// state | meaning
// IDLE  | no operation in flight, arbitrating between requesters
// WAIT  | ALU inputs held, settle counter running down to capture
// RESP  | response registered, waiting for rsp_ready
module alu_share_arbiter #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   input  logic             alu_overflow,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_overflow,
   output logic             rsp_zero,
   output logic             busy
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          rr;
   logic          id;
   logic [CW-1:0] cnt;
   logic          grant_any;
   logic          grant_id;
   logic          accept;
   logic          capture;
   logic          handoff;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Arbitration, handshake strobes and next state
   always_comb begin
      state_nxt  = state;
      grant_any  = 1'b0;
      grant_id   = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      handoff    = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (req0_valid && req1_valid) begin
               grant_any = 1'b1;
               grant_id  = rr;
            end else if (req0_valid) begin
               grant_any = 1'b1;
               grant_id  = 1'b0;
            end else if (req1_valid) begin
               grant_any = 1'b1;
               grant_id  = 1'b1;
            end
            // Readys stay low while reset is held even though state reads IDLE.
            req0_ready = grant_any && !grant_id && !reset;
            req1_ready = grant_any && grant_id && !reset;
            accept     = grant_any;
            if (accept) state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               handoff   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, settle counter, round-robin pointer and response register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr           <= 1'b0;
         id           <= 1'b0;
         cnt          <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_sel      <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
      end else begin
         if (accept) begin
            alu_a   <= grant_id ? req1_a  : req0_a;
            alu_b   <= grant_id ? req1_b  : req0_b;
            alu_sel <= grant_id ? req1_op : req0_op;
            id      <= grant_id;
            rr      <= ~grant_id;
            cnt     <= CNT_LOAD;
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (capture) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= id;
            rsp_result   <= alu_out;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
         end else if (handoff) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU that only produces a correct
// result once its inputs have been stable long enough, a transaction-level
// model of the arbiter checked every cycle, directed scenarios and a random
// phase.
module tb_alu_share_arbiter;
   localparam int W = 32;
   localparam int S = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic [2:0]     req0_op, req1_op;
   logic [W-1:0]   alu_a, alu_b;
   logic [2:0]     alu_sel;
   logic [W-1:0]   alu_out = '0;
   logic           alu_carry = 1'b0, alu_overflow = 1'b0, alu_zero = 1'b0;
   logic           rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0]   rsp_result;
   logic           rsp_carry, rsp_overflow, rsp_zero;
   logic           busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // {carry, overflow, zero, result}
   function automatic logic [W+2:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         c;
      logic         v;
      c = 1'b0;
      v = 1'b0;
      r = '0;
      s = '0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd1: begin
            s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd2: r = a ^ b;
         3'd3: r = ($signed(a) < $signed(b)) ? W'(1) : '0;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      return {c, v, (r == '0), r};
   endfunction

   // ALU: output is only correct once its inputs have been stable S-1 cycles.
   logic [2*W+2:0] alu_last = '0;
   int             alu_age  = 0;
   always @(negedge clk) begin : alu_model
      logic [W+2:0] f;
      if ({alu_a, alu_b, alu_sel} != alu_last) alu_age = 0;
      else if (alu_age < 1000) alu_age++;
      alu_last = {alu_a, alu_b, alu_sel};
      f = alu_ref(alu_a, alu_b, alu_sel);
      if (alu_age >= S - 1) {alu_carry, alu_overflow, alu_zero, alu_out} = f;
      else                  {alu_carry, alu_overflow, alu_zero, alu_out} = ~f;
   end

   // Transaction-level model: idle -> accepted op waits S edges -> response until taken
   bit           m_busy = 1'b0;
   bit           m_ptr  = 1'b0;
   int           m_wait = 0;
   bit           t_id;
   logic [W-1:0] t_a, t_b;
   logic [2:0]   t_op;
   logic [W+3:0] log_q[$];   // {id, carry, overflow, zero, result} of each handed-off response

   always @(negedge clk) begin : monitor
      bit           g_any;
      bit           g_id;
      logic [W+2:0] e;
      if (reset) begin
         m_busy = 1'b0;
         m_ptr  = 1'b0;
      end else if (!m_busy) begin
         g_any = req0_valid || req1_valid;
         g_id  = (req0_valid && req1_valid) ? m_ptr : !req0_valid;
         chk("ready0_idle", req0_ready, g_any && !g_id);
         chk("ready1_idle", req1_ready, g_any && g_id);
         chk("busy_idle", busy, 0);
         chk("rsp_valid_idle", rsp_valid, 0);
         if (g_any) begin
            m_busy = 1'b1;
            m_wait = S;
            t_id   = g_id;
            t_a    = g_id ? req1_a  : req0_a;
            t_b    = g_id ? req1_b  : req0_b;
            t_op   = g_id ? req1_op : req0_op;
            m_ptr  = !g_id;
         end
      end else begin
         chk("ready0_busy", req0_ready, 0);
         chk("ready1_busy", req1_ready, 0);
         chk("busy", busy, 1);
         chk("alu_a_hold", alu_a, t_a);
         chk("alu_b_hold", alu_b, t_b);
         chk("alu_sel_hold", alu_sel, t_op);
         if (m_wait > 0) begin
            chk("rsp_valid_wait", rsp_valid, 0);
            m_wait--;
         end else begin
            e = alu_ref(t_a, t_b, t_op);
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, t_id);
            chk("rsp_result", rsp_result, e[W-1:0]);
            chk("rsp_carry", rsp_carry, e[W+2]);
            chk("rsp_overflow", rsp_overflow, e[W+1]);
            chk("rsp_zero", rsp_zero, e[W]);
            if (rsp_ready) begin
               m_busy = 1'b0;
               log_q.push_back({rsp_id, rsp_carry, rsp_overflow, rsp_zero, rsp_result});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int n_before);
      int k;
      k = 0;
      while (log_q.size() <= n_before && k < 200) begin
         tick();
         k++;
      end
      chk("rsp_timeout", k < 200, 1);
   endtask

   task automatic issue(input bit n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      int k;
      if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
      else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
      k = 0;
      @(negedge clk);
      while (!(n ? req1_ready : req0_ready) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("grant_timeout", k < 200, 1);
      tick();
      if (n) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_word();
      case ($urandom_range(0, 4))
         0:       return '0;
         1:       return '1;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      logic [W+3:0] r;
      reset = 1'b1;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2; req0_op = 3'd0;
      req1_valid = 1'b1; req1_a = 32'h3; req1_b = 32'h4; req1_op = 3'd0;
      repeat (3) tick();
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_rsp_result", rsp_result, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b0;
      tick();

      // single ADD 5+7
      n = log_q.size();
      issue(0, 32'd5, 32'd7, 3'd0);
      wait_rsp(n);
      r = log_q[n];
      chk("t1_result", r[W-1:0], 12);
      chk("t1_id", r[W+3], 0);
      chk("t1_carry", r[W+2], 0);
      chk("t1_zero", r[W], 0);

      // put the pointer back on req0, then contention
      n = log_q.size();
      issue(1, 32'hFF00, 32'h0FF0, 3'd4);
      wait_rsp(n);
      n = log_q.size();
      req0_valid = 1'b1; req0_a = 32'd3;    req0_b = 32'd3;    req0_op = 3'd1;
      req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = 3'd7;
      for (int k = 0; k < 200 && log_q.size() < n + 4; k++) tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("t2_count", log_q.size() >= n + 4, 1);
      if (log_q.size() >= n + 4) begin
         for (int i = 0; i < 4; i++) begin
            r = log_q[n+i];
            chk("t2_order", r[W+3], i % 2);
            chk("t2_result", r[W-1:0], (i % 2) ? 32'hFF : 32'h0);
            chk("t2_zero", r[W], (i % 2) ? 0 : 1);
         end
      end
      repeat (S + 3) tick();

      // backpressure with the other requester waiting
      rsp_ready = 1'b0;
      n = log_q.size();
      issue(0, 32'd20, 32'd22, 3'd0);
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'd2;
      for (int k = 0; k < 50 && !rsp_valid; k++) tick();
      repeat (10) tick();
      chk("t3_no_early_handoff", log_q.size(), n);
      rsp_ready = 1'b1;
      wait_rsp(n);
      req1_valid = 1'b0;
      chk("t3_result", log_q[n][W-1:0], 42);
      repeat (S + 3) tick();

      // overflow / carry corners
      n = log_q.size();
      issue(0, 32'h7FFF_FFFF, 32'd1, 3'd0);
      wait_rsp(n);
      r = log_q[n];
      chk("t4_ovf_result", r[W-1:0], 32'h8000_0000);
      chk("t4_ovf_flag", r[W+1], 1);
      chk("t4_ovf_carry", r[W+2], 0);
      n = log_q.size();
      issue(1, 32'hFFFF_FFFF, 32'd1, 3'd0);
      wait_rsp(n);
      r = log_q[n];
      chk("t4_wrap_result", r[W-1:0], 0);
      chk("t4_wrap_carry", r[W+2], 1);
      chk("t4_wrap_zero", r[W], 1);

      // reset during WAIT drops the op; req0 favoured afterwards
      tick();
      n = log_q.size();
      issue(1, 32'd9, 32'd9, 3'd0);
      #1 reset = 1'b1;
      #1;
      chk("t5_alu_a", alu_a, 0);
      chk("t5_alu_b", alu_b, 0);
      chk("t5_busy", busy, 0);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_ready0", req0_ready, 0);
      tick();
      reset = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd50; req0_b = 32'd8; req0_op = 3'd1;
      req1_valid = 1'b1; req1_a = 32'd1;  req1_b = 32'd2; req1_op = 3'd0;
      wait_rsp(n);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("t5_first_id", log_q[n][W+3], 0);
      chk("t5_first_result", log_q[n][W-1:0], 42);
      repeat (2 * S + 6) tick();

      // operand changes right after accept must not leak into the op
      n = log_q.size();
      issue(0, 32'd100, 32'd23, 3'd1);
      req0_a = 32'd555;
      req0_b = 32'd1;
      wait_rsp(n);
      chk("t6_result", log_q[n][W-1:0], 77);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         req0_valid = ($urandom_range(0, 1) == 1);
         req1_valid = ($urandom_range(0, 1) == 1);
         req0_a = rand_word(); req0_b = rand_word(); req0_op = 3'($urandom_range(0, 7));
         req1_a = rand_word(); req1_b = rand_word(); req1_op = 3'($urandom_range(0, 7));
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (2 * S + 6) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
